// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM duty ramp controller.
package pwm_ramp_pkg;

    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} ramp_state_t;

    localparam int DUTY_W = 11;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'h7FF;

endpackage

// File: rtl/pwm_period_tmr.sv
// Purpose: free-running 2048-clock period counter plus step prescaler (period_end, step_tick).
// Latency: period_end decodes the registered counter directly; step_tick on the completing period_end.
// Backpressure: none; step_clr restarts the prescaler so a new ramp waits full periods.
module pwm_period_tmr
    import pwm_ramp_pkg::*;
#(
    parameter int PERIODS_PER_STEP = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_clr,
    output logic period_end,
    output logic step_tick
);

    localparam logic [7:0] STEP_LAST = 8'(PERIODS_PER_STEP - 1);

    logic [DUTY_W-1:0] cnt;
    logic [7:0]        step_cnt;

    assign period_end = (cnt == DUTY_MAX);
    assign step_tick  = period_end && (step_cnt == STEP_LAST);

    // Same reset as the PWM counter keeps period_end phase-aligned with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            step_cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (step_clr || step_tick) begin
                step_cnt <= '0;
            end else if (period_end) begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Purpose: ramps the PWM11 duty toward a handshaked target in STEP increments; optional breathing via PWM_RAMP_BREATHE_EN.
// Latency: first duty change PERIODS_PER_STEP period_ends after acceptance; duty only moves on period_end.
// Backpressure: tgt_rdy is low for the whole ramp; targets offered meanwhile are ignored.
module pwm_ramp_ctrl
    import pwm_ramp_pkg::*;
#(
    parameter int STEP             = 16,
    parameter int PERIODS_PER_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic              tgt_vld,
    output logic              tgt_rdy,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done,
    input  logic              breathe
);

    localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(STEP);

    ramp_state_t       state;
    logic [DUTY_W-1:0] tgt;
    logic              dn;

    logic              accept;
    logic [DUTY_W-1:0] new_tgt;
    logic              period_end;
    logic              step_tick;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   dn_diff;
    logic [DUTY_W-1:0] ramp_nxt;

    pwm_period_tmr #(
        .PERIODS_PER_STEP(PERIODS_PER_STEP)
    ) u_tmr (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_clr   (accept),
        .period_end (period_end),
        .step_tick  (step_tick)
    );

    always_comb begin
        accept  = 1'b0;
        new_tgt = tgt_duty;
        if (state == IDLE) begin
            if (tgt_vld) begin
                accept = 1'b1;
            end
`ifdef PWM_RAMP_BREATHE_EN
            else if (breathe) begin
                accept  = 1'b1;
                new_tgt = duty[DUTY_W-1] ? '0 : DUTY_MAX;
            end
`endif
        end
    end

`ifndef PWM_RAMP_BREATHE_EN
    logic breathe_unused;
    assign breathe_unused = breathe;
`endif

    // One extra bit so a step past either rail is seen and clamped instead of wrapping.
    always_comb begin
        up_sum  = {1'b0, duty} + STEP_X;
        dn_diff = {1'b0, duty} - STEP_X;
        if (dn) begin
            ramp_nxt = (dn_diff[DUTY_W] || (dn_diff[DUTY_W-1:0] <= tgt)) ? tgt : dn_diff[DUTY_W-1:0];
        end else begin
            ramp_nxt = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[DUTY_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tgt     <= '0;
            dn      <= 1'b0;
            duty    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tgt_rdy <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt <= new_tgt;
                        if (new_tgt == duty) begin
                            done <= 1'b1;
                        end else begin
                            state   <= RAMP;
                            dn      <= (new_tgt < duty);
                            busy    <= 1'b1;
                            tgt_rdy <= 1'b0;
                        end
                    end
                end
                RAMP: begin
                    if (step_tick) begin
                        duty <= ramp_nxt;
                        if (ramp_nxt == tgt) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            tgt_rdy <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: a fine-step instance and a coarse-step instance against a plain arithmetic ramp model.
module tb_pwm_ramp_ctrl;

    localparam int S0  = 16;
    localparam int S1  = 680;
    localparam int PPS = 1;
    localparam int PER = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tv    [2];
    logic [10:0] td    [2];
    logic        brth  [2];
    logic [10:0] duty_o[2];
    logic        rdy_o [2];
    logic        busy_o[2];
    logic        done_o[2];

    int checks = 0;
    int failures = 0;
    int exp_duty[2];
    int cyc;
    int accept_cyc;
    int first_lat;

    always #5 clk = ~clk;

    // Edges since reset release; the PWM period boundary is every multiple of 2048.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    pwm_ramp_ctrl #(.STEP(S0), .PERIODS_PER_STEP(PPS)) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_duty(td[0]), .tgt_vld(tv[0]), .tgt_rdy(rdy_o[0]),
        .duty(duty_o[0]), .busy(busy_o[0]), .done(done_o[0]), .breathe(brth[0])
    );

    pwm_ramp_ctrl #(.STEP(S1), .PERIODS_PER_STEP(PPS)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_duty(td[1]), .tgt_vld(tv[1]), .tgt_rdy(rdy_o[1]),
        .duty(duty_o[1]), .busy(busy_o[1]), .done(done_o[1]), .breathe(brth[1])
    );

    function automatic int next_duty(input int d, input int t, input int s);
        if (t > d) return (d + s > t) ? t : d + s;
        return (d - s < t) ? t : d - s;
    endfunction

    task automatic do_target(input int u, input int t, input string name);
        int n = 0;
        while (rdy_o[u] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (rdy_o[u] !== 1'b1) begin
            $display("FAIL %s rdy_wait: tgt_rdy=%b expected 1", name, rdy_o[u]); failures++;
        end
        tv[u] = 1'b1;
        td[u] = 11'(t);
        @(posedge clk);
        @(negedge clk);
        tv[u] = 1'b0;
        accept_cyc = cyc;
        checks++;
        if (t == exp_duty[u]) begin
            if (done_o[u] !== 1'b1 || busy_o[u] !== 1'b0 || duty_o[u] !== 11'(t)) begin
                $display("FAIL %s equal_accept: done=%b busy=%b duty=%0d expected done=1 busy=0 duty=%0d",
                         name, done_o[u], busy_o[u], duty_o[u], t); failures++;
            end
            @(negedge clk);
            checks++;
            if (done_o[u] !== 1'b0 || duty_o[u] !== 11'(t)) begin
                $display("FAIL %s equal_after: done=%b duty=%0d expected done=0 duty=%0d",
                         name, done_o[u], duty_o[u], t); failures++;
            end
        end else if (busy_o[u] !== 1'b1 || rdy_o[u] !== 1'b0 || done_o[u] !== 1'b0) begin
            $display("FAIL %s accept: busy=%b rdy=%b done=%b expected busy=1 rdy=0 done=0",
                     name, busy_o[u], rdy_o[u], done_o[u]); failures++;
        end
    endtask

    task automatic check_ramp(input int u, input int t, input int s, input string name);
        int  nxt;
        int  n;
        int  prev = 0;
        bit  first = 1'b1;
        while (exp_duty[u] != t) begin
            nxt = next_duty(exp_duty[u], t, s);
            n = 0;
            while (duty_o[u] === 11'(exp_duty[u]) && n < PER * PPS + 50) begin @(negedge clk); n++; end
            checks++;
            if (duty_o[u] !== 11'(nxt)) begin
                $display("FAIL %s step: duty=%0d expected %0d", name, duty_o[u], nxt); failures++;
                exp_duty[u] = int'(duty_o[u]);
                return;
            end
            checks++;
            if (cyc % PER != 0) begin
                $display("FAIL %s boundary: change at cycle %0d expected multiple of %0d", name, cyc, PER); failures++;
            end
            if (first) begin
                first_lat = cyc - accept_cyc;
            end else begin
                checks++;
                if (cyc - prev != PER * PPS) begin
                    $display("FAIL %s spacing: %0d clocks expected %0d", name, cyc - prev, PER * PPS); failures++;
                end
            end
            prev = cyc;
            first = 1'b0;
            exp_duty[u] = nxt;
            checks++;
            if (nxt == t) begin
                if (done_o[u] !== 1'b1 || rdy_o[u] !== 1'b1 || busy_o[u] !== 1'b0) begin
                    $display("FAIL %s finish: done=%b rdy=%b busy=%b expected 1 1 0",
                             name, done_o[u], rdy_o[u], busy_o[u]); failures++;
                end
            end else if (done_o[u] !== 1'b0 || busy_o[u] !== 1'b1 || rdy_o[u] !== 1'b0) begin
                $display("FAIL %s midramp: done=%b busy=%b rdy=%b expected 0 1 0",
                         name, done_o[u], busy_o[u], rdy_o[u]); failures++;
            end
        end
        @(negedge clk);
        checks++;
        if (done_o[u] !== 1'b0) begin
            $display("FAIL %s done_width: done=%b expected 0", name, done_o[u]); failures++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (duty_o[u] !== 11'd0 || rdy_o[u] !== 1'b1 || busy_o[u] !== 1'b0 || done_o[u] !== 1'b0) begin
                $display("FAIL reset_vals u%0d: duty=%0d rdy=%b busy=%b done=%b expected 0 1 0 0",
                         u, duty_o[u], rdy_o[u], busy_o[u], done_o[u]); failures++;
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (duty_o[0] !== 11'd0 || rdy_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL reset_hold: %0d cycles deviated expected 0", bad); failures++;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_target(0, 200, "reset_mid");
        while (duty_o[0] !== 11'd48 && n < 4 * PER + 50) begin @(negedge clk); n++; end
        checks++;
        if (duty_o[0] !== 11'd48) begin
            $display("FAIL reset_mid reach48: duty=%0d expected 48", duty_o[0]); failures++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (duty_o[0] !== 11'd0 || busy_o[0] !== 1'b0 || rdy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
            $display("FAIL reset_mid async: duty=%0d busy=%b rdy=%b done=%b expected 0 0 1 0",
                     duty_o[0], busy_o[0], rdy_o[0], done_o[0]); failures++;
        end
        exp_duty[0] = 0;
        exp_duty[1] = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_up();
        do_target(0, 64, "ramp_up");
        check_ramp(0, 64, S0, "ramp_up");
        checks++;
        if (first_lat < (PPS - 1) * PER + 1 || first_lat > PPS * PER) begin
            $display("FAIL ramp_up latency: %0d clocks expected %0d..%0d", first_lat, (PPS - 1) * PER + 1, PPS * PER);
            failures++;
        end
    endtask

    task automatic test_equal();
        do_target(0, exp_duty[0], "equal");
    endtask

    task automatic test_vld_held();
        do_target(0, 96, "vld_held");
        tv[0] = 1'b1;
        td[0] = 11'd40;
        check_ramp(0, 96, S0, "vld_held_first");
        tv[0] = 1'b0;
        checks++;
        if (busy_o[0] !== 1'b1 || rdy_o[0] !== 1'b0 || duty_o[0] !== 11'd96) begin
            $display("FAIL vld_held second_accept: busy=%b rdy=%b duty=%0d expected 1 0 96",
                     busy_o[0], rdy_o[0], duty_o[0]); failures++;
        end
        check_ramp(0, 40, S0, "vld_held_second");
    endtask

    task automatic test_random();
        int t;
        int delta;
        for (int k = 0; k < 2; k++) begin
            delta = int'($urandom_range(1, 2 * S0));
            t = ($urandom_range(0, 1) == 0) ? exp_duty[0] + delta : exp_duty[0] - delta;
            if (t < 0) t = 0;
            if (t > 2047) t = 2047;
            do_target(0, t, "random");
            check_ramp(0, t, S0, "random");
        end
    endtask

    task automatic test_extremes();
        do_target(1, 2040, "ext_up");
        check_ramp(1, 2040, S1, "ext_up");
        do_target(1, 2047, "ext_top");
        check_ramp(1, 2047, S1, "ext_top");
        do_target(1, 5, "ext_down");
        check_ramp(1, 5, S1, "ext_down");
    endtask

    task automatic test_breathe();
        int bad = 0;
`ifdef PWM_RAMP_BREATHE_EN
        brth[1] = 1'b1;
        @(negedge clk);
        check_ramp(1, 2047, S1, "breathe_up");
        brth[1] = 1'b0;
        checks++;
        if (busy_o[1] !== 1'b1) begin
            $display("FAIL breathe_reissue: busy=%b expected 1", busy_o[1]); failures++;
        end
        check_ramp(1, 0, S1, "breathe_down");
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if (duty_o[1] !== 11'd0 || busy_o[1] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL breathe_stop: %0d cycles moved expected 0", bad); failures++;
        end
`else
        brth[1] = 1'b1;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if (duty_o[1] !== 11'(exp_duty[1]) || busy_o[1] !== 1'b0 || rdy_o[1] !== 1'b1) bad++;
        end
        brth[1] = 1'b0;
        checks++;
        if (bad != 0) begin
            $display("FAIL breathe_ignored: %0d cycles moved expected 0", bad); failures++;
        end
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            tv[u] = 1'b0;
            td[u] = 11'd0;
            brth[u] = 1'b0;
            exp_duty[u] = 0;
        end
        test_reset();
        test_reset_mid();
        test_ramp_up();
        test_equal();
        test_vld_held();
        test_random();
        test_extremes();
        test_breathe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
